ate_param_stream: RTL
=====================

// Module: ate_param_stream
// PURPOSE
//  Parametrised, streaming successor of the adaptive threshold engine. Pixels arrive in
//  block order (BLK_PIX consecutive pixels = one block) with a valid qualifier. Each block
//  is buffered while its min/max is tracked; threshold = rounded midpoint of min and max.
//  The block is then replayed as binarised pixels from a ping-pong buffer, overlapped
//  with capture of the next block. Optional border mode forces the first and last
//  block of each block-row to threshold 0.
// PARAMETERS
//  PIX_W       8   pixel and threshold width in bits
//  BLK_PIX     64  pixels per block (>=2); CNT_W = $clog2(BLK_PIX)
//  BLK_PER_ROW 4   blocks per block-row (>=1); used only by border mode
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-high
//  in_valid   in   1      pix_data/sof valid this cycle
//  pix_data   in   PIX_W  input pixel
//  sof        in   1      with in_valid: this pixel is pixel 0 of block 0 of a new frame
//  border_en  in   1      border mode enable, sampled with the last pixel of each block
//  out_valid  out  1      bin/threshold/out_last valid
//  bin        out  1      1 when replayed pixel >= threshold
//  threshold  out  PIX_W  threshold of the block being replayed, constant across the block
//  out_last   out  1      marks last replayed pixel of a block
// BEHAVIOUR
//  - Reset (async): out_valid=0, bin=0, threshold=0, out_last=0; pixel count=0, block
//    index=0, write bank=0, replay idle. Buffer RAM is not cleared (never read before fill).
//  - Capture: on each edge with in_valid=1, write pix_data at [wbank][cnt], cnt+1.
//    Pixel 0 of a block loads min=max=pix_data; later pixels update min/max. No stall;
//    in_valid may drop for any number of cycles, and all state holds.
//  - Block close: edge accepting cnt==BLK_PIX-1: cnt->0; thr = (min'+max'+1)>>1 using a
//    PIX_W+1-bit sum, with min'/max' including this pixel. If border_en=1 and block
//    index is 0 or BLK_PER_ROW-1, thr=0. Block index wraps BLK_PER_ROW-1 -> 0.
//    wbank toggles; the closed bank is handed to replay.
//  - Replay: starts the cycle after block close. Outputs one pixel per cycle for
//    BLK_PIX consecutive cycles, unconditionally and independent of in_valid:
//    out_valid=1, bin=(buf[k]>=thr), threshold=thr, out_last=(k==BLK_PIX-1).
//    Latency: replayed pixel k appears k+1 cycles after the close edge.
//    After replay, out_valid=0 and bin=0; threshold holds its last value.
//  - Overlap: input rate <=1/cycle guarantees replay of bank A ends before bank B closes.
//    Back-to-back close edges, with a close on the cycle after the last replay pixel, give
//    gap-free out_valid.
//  - sof with in_valid: pixel is written as cnt=0, block index=0; any partial block is
//    discarded and min/max restart. An in-progress replay continues undisturbed.
//  - Equal pixels in a block: threshold equals that value, so all bin=1.
//    Arithmetic is unsigned.
//  - Reset mid-replay aborts the replay immediately, with outputs at reset values.
// STRUCTURE
//  - Package ate_pkg: default PIX_W/BLK_PIX/BLK_PER_ROW localparams,
//    function ate_mid(min,max) returning the rounded midpoint.
//  - Sub-module ate_minmax_tracker: load/update running min and max, PIX_W parametrised.
//  - Top holds capture counter, block index, 2xBLK_PIX buffer, replay counter/FSM
//    (IDLE, REPLAY).
// TESTING
//  1 Block pixels 0..63 with defaults, border_en=0 -> threshold=32 (31.5 rounded up);
//    bin=0 for pixels 0..31 and 1 for 32..63; out_last only on 64th pixel.
//  2 Block all 8'd200 -> threshold=200, 64x bin=1; block {0,255,...} -> threshold=128.
//  3 Four blocks of random data, border_en=1 -> blocks 0 and 3 threshold=0 with all bin=1;
//    blocks 1 and 2 match model; fifth block index wraps to 0 and gets threshold 0.
//  4 in_valid toggling 50% random -> output sequence identical to continuous case;
//    replay always 64 consecutive cycles; no overlap or loss.
//  5 sof asserted at pixel 20 of a block -> partial block dropped; next close after 64
//    more pixels; threshold computed only from post-sof pixels.
//  6 reset asserted at replay pixel 10 -> out_valid, bin and threshold 0 in the same cycle;
//    next full block after release replays correctly.

Source files
------------

// File: rtl/ate_pkg.sv
// Shared defaults and arithmetic helpers for the adaptive threshold engine.
package ate_pkg;

   localparam int unsigned ATE_PIX_W       = 8;
   localparam int unsigned ATE_BLK_PIX     = 64;
   localparam int unsigned ATE_BLK_PER_ROW = 4;

   // Rounded midpoint; the wide sum cannot overflow for any PIX_W up to 32.
   function automatic logic [31:0] ate_mid(input logic [31:0] mn, input logic [31:0] mx);
      logic [32:0] sum;
      sum = {1'b0, mn} + {1'b0, mx} + 33'd1;
      return sum[32:1];
   endfunction

endpackage

// File: rtl/ate_minmax_tracker.sv
// Running min/max of a pixel block; outputs include the pixel presented this cycle.
module ate_minmax_tracker
   import ate_pkg::*;
#(
   parameter int unsigned PIX_W = ATE_PIX_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [PIX_W-1:0] din,
   output logic [PIX_W-1:0] run_min,
   output logic [PIX_W-1:0] run_max
);

   logic [PIX_W-1:0] min_q;
   logic [PIX_W-1:0] max_q;

   always_comb begin
      run_min = min_q;
      run_max = max_q;
      if (load) begin
         run_min = din;
         run_max = din;
      end else begin
         if (din < min_q) run_min = din;
         if (din > max_q) run_max = din;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         min_q <= '0;
         max_q <= '0;
      end else if (en) begin
         min_q <= run_min;
         max_q <= run_max;
      end
   end

endmodule

// File: rtl/ate_param_stream.sv
// Streaming adaptive threshold engine: captures a block into one half of a
// ping-pong buffer while the other half is replayed as binarised pixels.
module ate_param_stream
   import ate_pkg::*;
#(
   parameter int unsigned PIX_W       = ATE_PIX_W,
   parameter int unsigned BLK_PIX     = ATE_BLK_PIX,
   parameter int unsigned BLK_PER_ROW = ATE_BLK_PER_ROW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [PIX_W-1:0] pix_data,
   input  logic             sof,
   input  logic             border_en,
   output logic             out_valid,
   output logic             bin,
   output logic [PIX_W-1:0] threshold,
   output logic             out_last
);

   localparam int unsigned CNT_W = $clog2(BLK_PIX);
   localparam int unsigned IDX_W = (BLK_PER_ROW > 1) ? $clog2(BLK_PER_ROW) : 1;
   localparam int unsigned ADR_W = CNT_W + 1;

   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(BLK_PIX - 1);
   localparam logic [IDX_W-1:0] LAST_BLK = IDX_W'(BLK_PER_ROW - 1);
   localparam logic [ADR_W-1:0] BANK_OFS = ADR_W'(BLK_PIX);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_REPLAY = 1'b1;

   logic [PIX_W-1:0] buf_mem [2*BLK_PIX];

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cap_cnt;
   logic [IDX_W-1:0] blk_idx;
   logic [IDX_W-1:0] cap_idx;
   logic             wbank;
   logic             rbank;
   logic             load;
   logic             close;
   logic [PIX_W-1:0] run_min;
   logic [PIX_W-1:0] run_max;
   logic [PIX_W-1:0] blk_thr;
   logic [PIX_W-1:0] rthr;
   logic [0:0]       state;
   logic [CNT_W-1:0] rcnt;
   logic [ADR_W-1:0] waddr;
   logic [ADR_W-1:0] raddr;
   logic [PIX_W-1:0] rpix;

   // sof overrides the stored position so the flagged pixel starts a fresh block 0.
   always_comb begin
      cap_cnt = sof ? '0 : cnt;
      cap_idx = sof ? '0 : blk_idx;
      load    = (cap_cnt == '0);
      close   = in_valid && (cap_cnt == LAST_PIX);
      blk_thr = PIX_W'(ate_mid(32'(run_min), 32'(run_max)));
      if (border_en && ((cap_idx == '0) || (cap_idx == LAST_BLK)))
         blk_thr = '0;
      waddr = ADR_W'(cap_cnt) + (wbank ? BANK_OFS : '0);
      raddr = ADR_W'(rcnt) + (rbank ? BANK_OFS : '0);
      rpix  = buf_mem[raddr];
   end

   ate_minmax_tracker #(
      .PIX_W(PIX_W)
   ) u_minmax (
      .clk    (clk),
      .reset  (reset),
      .en     (in_valid),
      .load   (load),
      .din    (pix_data),
      .run_min(run_min),
      .run_max(run_max)
   );

   always_ff @(posedge clk) begin
      if (in_valid) buf_mem[waddr] <= pix_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         blk_idx <= '0;
         wbank   <= 1'b0;
         rbank   <= 1'b0;
         rthr    <= '0;
      end else if (in_valid) begin
         if (close) begin
            cnt     <= '0;
            blk_idx <= (cap_idx == LAST_BLK) ? '0 : cap_idx + 1'b1;
            wbank   <= ~wbank;
            rbank   <= wbank;
            rthr    <= blk_thr;
         end else begin
            cnt     <= cap_cnt + 1'b1;
            blk_idx <= cap_idx;
         end
      end
   end

   // A close coinciding with the last replay beat restarts replay without a gap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         rcnt      <= '0;
         out_valid <= 1'b0;
         bin       <= 1'b0;
         threshold <= '0;
         out_last  <= 1'b0;
      end else begin
         if (state == ST_REPLAY) begin
            out_valid <= 1'b1;
            bin       <= (rpix >= rthr);
            threshold <= rthr;
            out_last  <= (rcnt == LAST_PIX);
            rcnt      <= rcnt + 1'b1;
         end else begin
            out_valid <= 1'b0;
            bin       <= 1'b0;
            out_last  <= 1'b0;
         end
         if (close) begin
            state <= ST_REPLAY;
            rcnt  <= '0;
         end else if ((state == ST_REPLAY) && (rcnt == LAST_PIX)) begin
            state <= ST_IDLE;
         end
      end
   end

endmodule
